// File: rtl/tennis_pkg.sv
// Shared definitions for the tennis game: court width, score width,
// referee state encoding and player ids.
package tennis_pkg;

  localparam int LED_W   = 16;  // ball-position bar width shared with the ball mover
  localparam int SCORE_W = 4;   // score counter width (max 15)

  // Referee states
  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_RALLY = 2'd1,
    S_POINT = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  // Player ids; also used as index into per-player vectors
  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  // Per-player registered command pulses, indexed by player id
  typedef struct packed {
    logic [1:0] serve;
    logic [1:0] hit;
    logic [1:0] point;
  } pulses_t;

endpackage

// File: rtl/rally_referee_btn_edge.sv
// Rising-edge detector for one debounced button level. The previous level
// is registered; a press is a cycle where the level is high but was low.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic btn_q;

  // Remember last cycle's level so a held button never re-triggers
  always_ff @(posedge clk) begin
    if (reset) btn_q <= 1'b0;
    else       btn_q <= btn;
  end

  assign press = btn & ~btn_q;

endmodule

// File: rtl/rally_referee.sv
// Rally referee: judges serves, returns and misses from the ball bar and
// player buttons, keeps score and declares the winner. All command pulses
// are registered, one clk after the qualifying sample.
module rally_referee
  import tennis_pkg::*;
#(
  parameter int N_LED       = LED_W,
  parameter int WIN_SCORE   = 7,
  parameter int POINT_TICKS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [N_LED-1:0]   led,
  input  logic               btn_p1,
  input  logic               btn_p2,
  output logic               serve_p1,
  output logic               serve_p2,
  output logic               hit_p1,
  output logic               hit_p2,
  output logic               point_p1,
  output logic               point_p2,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               game_over,
  output logic               winner
);

  localparam int TICK_W = (POINT_TICKS > 1) ? $clog2(POINT_TICKS) : 1;

  state_t                    state;
  logic                      server;    // who serves next
  logic                      expect_p;  // end the ball is travelling toward
  logic [1:0][SCORE_W-1:0]   score;
  logic [TICK_W-1:0]         tick_cnt;
  pulses_t                   pul;
  logic [1:0]                press;

  // One edge detector per player, indexed by player id
  btn_edge u_edge [1:0] (
    .clk   (clk),
    .reset (reset),
    .btn   ({btn_p2, btn_p1}),
    .press (press)
  );

  // On a miss the point goes to the player the ball was NOT heading for
  logic               scorer;
  logic [SCORE_W-1:0] next_pts;
  logic               at_end;

  assign scorer   = ~expect_p;
  assign next_pts = score[scorer] + 1'b1;
  assign at_end   = (expect_p == P1) ? led[N_LED-1] : led[0];

  // Referee FSM with score and post-point tick counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_SERVE;
      server    <= P1;
      expect_p  <= P2;
      score     <= '0;
      tick_cnt  <= '0;
      pul       <= '0;
      game_over <= 1'b0;
      winner    <= P1;
    end else begin
      pul <= '0;
      case (state)
        S_SERVE: begin
          if (press[server]) begin
            pul.serve[server] <= 1'b1;
            expect_p          <= ~server;
            state             <= S_RALLY;
          end
        end
        S_RALLY: begin
          // Ball off the court wins over any same-cycle return
          if (led == '0) begin
            pul.point[scorer] <= 1'b1;
            score[scorer]     <= next_pts;
            server            <= scorer;
            tick_cnt          <= '0;
            if (next_pts == SCORE_W'(WIN_SCORE)) begin
              state     <= S_OVER;
              game_over <= 1'b1;
              winner    <= scorer;
            end else begin
              state <= S_POINT;
            end
          end else if (press[expect_p] && at_end) begin
            pul.hit[expect_p] <= 1'b1;
            expect_p          <= ~expect_p;
          end
        end
        S_POINT: begin
          if (tick) begin
            if (tick_cnt == TICK_W'(POINT_TICKS - 1)) begin
              tick_cnt <= '0;
              state    <= S_SERVE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        S_OVER:  ;
        default: state <= S_SERVE;
      endcase
    end
  end

  assign serve_p1 = pul.serve[P1];
  assign serve_p2 = pul.serve[P2];
  assign hit_p1   = pul.hit[P1];
  assign hit_p2   = pul.hit[P2];
  assign point_p1 = pul.point[P1];
  assign point_p2 = pul.point[P2];
  assign score_p1 = score[P1];
  assign score_p2 = score[P2];

endmodule

// File: tb/tb_rally_referee.sv
// Bench for rally_referee: directed vector table, hand sequences for the
// game-end and reset corners, then random play against a reference model.
module tb_rally_referee;

  logic        clk = 1'b0;
  logic        reset = 1'b1, tick = 1'b0, btn_p1 = 1'b0, btn_p2 = 1'b0;
  logic [15:0] led = 16'h0100;
  logic        serve_p1, serve_p2, hit_p1, hit_p2, point_p1, point_p2;
  logic [3:0]  score_p1, score_p2;
  logic        game_over, winner;

  rally_referee dut (
    .clk(clk), .reset(reset), .tick(tick), .led(led),
    .btn_p1(btn_p1), .btn_p2(btn_p2),
    .serve_p1(serve_p1), .serve_p2(serve_p2),
    .hit_p1(hit_p1), .hit_p2(hit_p2),
    .point_p1(point_p1), .point_p2(point_p2),
    .score_p1(score_p1), .score_p2(score_p2),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // pulse vector order: {serve_p1, serve_p2, hit_p1, hit_p2, point_p1, point_p2}
  logic [5:0] pv;
  assign pv = {serve_p1, serve_p2, hit_p1, hit_p2, point_p1, point_p2};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Drive inputs away from the edge, then sample just after the edge
  task automatic cyc(input logic r, input logic t, input logic [15:0] l,
                     input logic b1, input logic b2);
    @(negedge clk);
    reset = r; tick = t; led = l; btn_p1 = b1; btn_p2 = b2;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        tk;
    logic [15:0] l;
    logic        b1;
    logic        b2;
    logic [5:0]  pul;
    logic [3:0]  s1;
    logic [3:0]  s2;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic tk, input logic [15:0] l,
                              input logic b1, input logic b2, input logic [5:0] pul,
                              input logic [3:0] s1, input logic [3:0] s2);
    vec_t v;
    v.rst = rst; v.tk = tk; v.l = l; v.b1 = b1; v.b2 = b2;
    v.pul = pul; v.s1 = s1; v.s2 = s2;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // phase: 0 waiting for serve, 1 ball in play, 2 pause after point, 3 game finished
  int         m_phase, m_srv, m_to, m_left, m_win;
  int         m_sc [2];
  logic       m_go;
  logic [1:0] m_prev;
  logic [5:0] m_pul;

  task automatic model_step(input logic r, input logic t, input logic [15:0] l,
                            input logic b1, input logic b2);
    logic [1:0] pr;
    int s;
    m_pul = '0;
    if (r) begin
      m_phase = 0; m_srv = 0; m_to = 1; m_left = 0; m_win = 0;
      m_sc[0] = 0; m_sc[1] = 0; m_go = 1'b0; m_prev = 2'b00;
      return;
    end
    pr = {b2, b1} & ~m_prev;
    m_prev = {b2, b1};
    if (m_phase == 0) begin
      if (pr[m_srv]) begin
        m_pul[5 - m_srv] = 1'b1;
        m_to = 1 - m_srv;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (l == 16'h0000) begin
        s = 1 - m_to;
        m_sc[s] = m_sc[s] + 1;
        m_pul[1 - s] = 1'b1;
        m_srv = s;
        if (m_sc[s] == 7) begin
          m_phase = 3; m_go = 1'b1; m_win = s;
        end else begin
          m_phase = 2; m_left = 4;
        end
      end else if (pr[m_to] && ((m_to == 0) ? l[15] : l[0])) begin
        m_pul[3 - m_to] = 1'b1;
        m_to = 1 - m_to;
      end
    end else if (m_phase == 2) begin
      if (t) begin
        m_left = m_left - 1;
        if (m_left == 0) m_phase = 0;
      end
    end
  endtask

  vec_t tbl [19];

  initial begin
    // ---------------- directed table ----------------
    tbl[0]  = mk(1, 0, 16'h0100, 0, 0, 6'b000000, 0, 0); // reset state
    tbl[1]  = mk(0, 0, 16'h0100, 0, 1, 6'b000000, 0, 0); // non-server press ignored
    tbl[2]  = mk(0, 0, 16'h0100, 0, 0, 6'b000000, 0, 0);
    tbl[3]  = mk(0, 0, 16'h0100, 1, 0, 6'b100000, 0, 0); // P1 serves
    tbl[4]  = mk(0, 0, 16'h0100, 1, 0, 6'b000000, 0, 0); // pulse one cycle, held no retrigger
    tbl[5]  = mk(0, 0, 16'h0001, 0, 1, 6'b000100, 0, 0); // P2 legal return
    tbl[6]  = mk(0, 0, 16'h0001, 0, 1, 6'b000000, 0, 0); // held button
    tbl[7]  = mk(0, 0, 16'h0100, 0, 0, 6'b000000, 0, 0);
    tbl[8]  = mk(0, 0, 16'h8000, 1, 1, 6'b001000, 0, 0); // both pressed, only P1 hits
    tbl[9]  = mk(0, 0, 16'h0100, 0, 0, 6'b000000, 0, 0);
    tbl[10] = mk(0, 0, 16'h0004, 0, 1, 6'b000000, 0, 0); // early swing ignored
    tbl[11] = mk(0, 0, 16'h0000, 0, 0, 6'b000010, 1, 0); // P2 misses, point P1
    tbl[12] = mk(0, 0, 16'h0000, 1, 0, 6'b000000, 1, 0); // buttons ignored in pause
    tbl[13] = mk(0, 1, 16'h0000, 0, 0, 6'b000000, 1, 0);
    tbl[14] = mk(0, 1, 16'h0000, 0, 0, 6'b000000, 1, 0);
    tbl[15] = mk(0, 1, 16'h0000, 0, 0, 6'b000000, 1, 0);
    tbl[16] = mk(0, 0, 16'h0000, 1, 0, 6'b000000, 1, 0); // one tick still owed
    tbl[17] = mk(0, 1, 16'h0100, 0, 0, 6'b000000, 1, 0); // fourth tick
    tbl[18] = mk(0, 0, 16'h0100, 1, 0, 6'b100000, 1, 0); // scorer P1 serves again

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].rst, tbl[i].tk, tbl[i].l, tbl[i].b1, tbl[i].b2);
      chk($sformatf("vec%0d pulses", i), {26'd0, pv}, {26'd0, tbl[i].pul});
      chk($sformatf("vec%0d score", i), {23'd0, score_p1, score_p2, game_over},
          {23'd0, tbl[i].s1, tbl[i].s2, 1'b0});
    end

    // ---------------- P2 wins 7-0 ----------------
    cyc(1, 0, 16'h0100, 0, 0);
    cyc(0, 0, 16'h0100, 1, 0); chk("win serve1", {26'd0, pv}, 32'b100000);
    cyc(0, 0, 16'h0001, 0, 1); chk("win hit2", {26'd0, pv}, 32'b000100);
    cyc(0, 0, 16'h0000, 0, 0); chk("win pt2 first", {26'd0, pv}, 32'b000001);
    chk("win score2 first", {28'd0, score_p2}, 32'd1);
    for (int k = 2; k <= 7; k++) begin
      repeat (4) cyc(0, 1, 16'h0100, 0, 0);
      cyc(0, 0, 16'h0100, 0, 1); chk($sformatf("win serve2 %0d", k), {26'd0, pv}, 32'b010000);
      cyc(0, 0, 16'h0000, 0, 0); chk($sformatf("win pt2 %0d", k), {26'd0, pv}, 32'b000001);
      chk($sformatf("win score2 %0d", k), {28'd0, score_p2}, k);
    end
    chk("win game_over", {31'd0, game_over}, 32'd1);
    chk("win winner", {31'd0, winner}, 32'd1);
    chk("win score1", {28'd0, score_p1}, 32'd0);
    for (int j = 0; j < 10; j++) begin
      cyc(0, (j % 2 == 1), (j % 3 == 0) ? 16'h0000 : ((j % 3 == 1) ? 16'h8000 : 16'h0001),
          (j % 2 == 0), (j % 2 == 1));
      chk($sformatf("over quiet %0d", j), {26'd0, pv}, 32'd0);
    end
    chk("over frozen", {23'd0, score_p1, score_p2, game_over}, {23'd0, 4'd0, 4'd7, 1'b1});

    // ---------------- reset during pause at 3-2 ----------------
    cyc(1, 0, 16'h0100, 0, 0);
    for (int j = 0; j < 3; j++) begin
      cyc(0, 0, 16'h0100, 1, 0); chk("rst serve1", {26'd0, pv}, 32'b100000);
      cyc(0, 0, 16'h0000, 0, 0); chk("rst pt1", {26'd0, pv}, 32'b000010);
      repeat (4) cyc(0, 1, 16'h0100, 0, 0);
    end
    cyc(0, 0, 16'h0100, 1, 0); chk("rst serve1 b", {26'd0, pv}, 32'b100000);
    cyc(0, 0, 16'h0001, 0, 1); chk("rst hit2", {26'd0, pv}, 32'b000100);
    cyc(0, 0, 16'h0000, 0, 0); chk("rst pt2 a", {26'd0, pv}, 32'b000001);
    repeat (4) cyc(0, 1, 16'h0100, 0, 0);
    cyc(0, 0, 16'h0100, 0, 1); chk("rst serve2", {26'd0, pv}, 32'b010000);
    cyc(0, 0, 16'h0000, 0, 0); chk("rst pt2 b", {26'd0, pv}, 32'b000001);
    chk("rst 3-2", {24'd0, score_p1, score_p2}, {24'd0, 4'd3, 4'd2});
    cyc(0, 1, 16'h0100, 0, 0);
    cyc(1, 0, 16'h0100, 0, 0);
    chk("rst cleared", {17'd0, pv, score_p1, score_p2, game_over}, 32'd0);
    cyc(0, 0, 16'h0100, 0, 1); chk("rst P2 not server", {26'd0, pv}, 32'd0);
    cyc(0, 0, 16'h0100, 1, 0); chk("rst P1 serves", {26'd0, pv}, 32'b100000);

    // ---------------- random play vs model ----------------
    for (int i = 0; i < 4000; i++) begin
      logic        r, t, b1, b2;
      logic [15:0] l;
      int          sel;
      r   = (i == 0) || ($urandom_range(0, 399) == 0);
      t   = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 11);
      if (sel == 0)      l = 16'h0000;
      else if (sel <= 3) l = 16'h8000;
      else if (sel <= 6) l = 16'h0001;
      else               l = 16'h0001 << $urandom_range(1, 14);
      b1 = ($urandom_range(0, 2) == 0);
      b2 = ($urandom_range(0, 2) == 0);
      model_step(r, t, l, b1, b2);
      cyc(r, t, l, b1, b2);
      chk($sformatf("rand %0d", i),
          {16'd0, pv, score_p1, score_p2, game_over, winner},
          {16'd0, m_pul, 4'(m_sc[0]), 4'(m_sc[1]), m_go, m_go & (m_win == 1)});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
